mem_stack_unit: RTL
===================

MEM_STACK_UNIT -- requirements
Module: mem_stack_unit

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 CLK  in  1  rising-edge clock.
REQ-003 RST_N  in  1  asynchronous active-low reset.
REQ-004 LoadReq  in  1  memory read request from control (LM).
REQ-005 StoreReq  in  1  memory write request from control (MW).
REQ-006 AddrSel  in  2  address source: 0=SP, 1=PC, 2=OpAddr, 3=reserved.
REQ-007 SPUpdate  in  1  stack op: with StoreReq=push, with LoadReq=pop.
REQ-008 PC, OpAddr, WData  in  16 each  address and write-data sources.
REQ-009 RData  out  16  last read data.
REQ-010 Busy  out  1  access in progress.
REQ-011 Done  out  1  one-cycle completion pulse.
REQ-012 SP  out  16  current stack pointer.
REQ-013 Error  out  1  one-cycle fault pulse.
REQ-014 MemReq, MemWE  out  1; MemAddr, MemWData  out  16; MemRData  in  16; MemAck  in  1: memory-side handshake.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS and DONE; requests SHALL be sampled only in IDLE and ignored in all other states.
REQ-016 IDLE->ACCESS on LoadReq xor StoreReq; LoadReq and StoreReq together SHALL pulse Error, start no access and stay in IDLE.
REQ-017 AddrSel=3 with a request SHALL pulse Error and stay in IDLE; SPUpdate without a request SHALL be ignored.
REQ-018 Push: SP decrements by 1 at acceptance; MemAddr=new SP; MemWData=WData latched at acceptance; AddrSel is ignored.
REQ-019 Pop: MemAddr=SP at acceptance; SP increments by 1 in the MemAck cycle; AddrSel is ignored.
REQ-020 Non-stack access: MemAddr, MemWData and MemWE SHALL be latched at acceptance from AddrSel, WData and StoreReq.
REQ-021 In ACCESS, MemReq=1, Busy=1, MemAddr/MemWE/MemWData SHALL be held stable until the cycle MemAck is sampled 1; that edge SHALL go to DONE and, for a load, register MemRData into RData.
REQ-022 In DONE, Done=1 and Busy=0 for exactly one cycle, then IDLE; minimum latency with zero-wait memory is request at cycle N, MemAck at N+1, Done at N+2.
REQ-023 RData SHALL hold its value until the next load completes; stores SHALL NOT change RData.
REQ-024 A 4-bit wait counter SHALL clear on entry to ACCESS; if MemAck is still 0 after 15 ACCESS cycles, the unit SHALL drop MemReq, pulse Error, restore SP to its pre-request value, and return to IDLE without Done.
REQ-025 SP arithmetic SHALL be 16-bit modulo 2^16 (0x0000-1=0xFFFF) unless REQ-031 applies.
REQ-026 MemAck while in IDLE or DONE SHALL be ignored.

Reset
REQ-027 On RST_N=0, immediately: state=IDLE, SP=SP_RESET (0x7FFF), RData=0, MemReq=0, MemWE=0, MemAddr=0, MemWData=0, Busy=0, Done=0, Error=0, wait counter=0.
REQ-028 Reset during ACCESS SHALL abort the transfer with no Done and no Error.

Configuration
REQ-029 Macro STACK_BOUND_CHECK_EN SHALL select stack bounds checking.
REQ-030 Without it, SP SHALL wrap per REQ-025 with no bounds fault.
REQ-031 With it, a push at SP=0x0000 or a pop at SP=SP_RESET SHALL pulse Error, start no access, and leave SP unchanged.

Structure
REQ-032 Package mem_unit_pkg SHALL hold the FSM state encoding, the AddrSel encodings, SP_RESET=16'h7FFF and TIMEOUT_CYCLES=15.
REQ-033 Sub-module stack_pointer SHALL own the SP register with decrement, increment, restore and bound-check logic; the FSM and memory handshake SHALL stay in mem_stack_unit.

Verification
REQ-034 Load with AddrSel=1, PC=0x0010, MemAck at first ACCESS cycle, MemRData=0xBEEF -> MemAddr=0x0010, Done at N+2, RData=0xBEEF.
REQ-035 Push with WData=0x1234 after reset -> MemAddr=0x7FFE, MemWE=1; then pop with MemRData=0x1234 -> MemAddr=0x7FFE, RData=0x1234, SP=0x7FFF.
REQ-036 Store with MemAck delayed 5 cycles -> Busy=1 for 5 ACCESS cycles, address and data stable throughout, Done one cycle after MemAck.
REQ-037 Store with MemAck never asserted -> Error pulse after 15 ACCESS cycles, MemReq=0, no Done, SP unchanged.
REQ-038 LoadReq=StoreReq=1 -> Error pulse, MemReq stays 0; pop at SP=0x7FFF -> Error with STACK_BOUND_CHECK_EN defined, SP=0x8000 without it.
REQ-039 RST_N low mid-ACCESS -> MemReq=0 immediately, SP=0x7FFF, no Done.

Source files
------------

// File: rtl/mem_unit_pkg.sv
// Shared encodings and constants for the memory/stack access unit.
package mem_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0]  SEL_SP     = 2'd0;
  localparam logic [1:0]  SEL_PC     = 2'd1;
  localparam logic [1:0]  SEL_OPADDR = 2'd2;
  localparam logic [1:0]  SEL_RSVD   = 2'd3;

  localparam logic [15:0] SP_RESET       = 16'h7FFF;
  localparam int          TIMEOUT_CYCLES = 15;
  // Wait-counter value seen during the last permitted ACCESS cycle.
  localparam logic [3:0]  WAIT_LAST      = 4'(TIMEOUT_CYCLES - 1);

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register with push/pop update, timeout restore and bound flags.
// Optional STACK_BOUND_CHECK_EN blocks push at 0x0000 and pop at SP_RESET.
module stack_pointer
  import mem_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop_done,
  input  logic        capture,
  input  logic        restore,
  output logic [15:0] sp,
  output logic        push_blocked,
  output logic        pop_blocked
);

  logic [15:0] sp_saved;

  // sp_saved holds the pre-request value so a timed-out access can be undone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp       <= SP_RESET;
      sp_saved <= SP_RESET;
    end else begin
      if (capture)
        sp_saved <= sp;
      if (restore)
        sp <= sp_saved;
      else if (push)
        sp <= sp - 16'd1;
      else if (pop_done)
        sp <= sp + 16'd1;
    end
  end

`ifdef STACK_BOUND_CHECK_EN
  assign push_blocked = (sp == 16'h0000);
  assign pop_blocked  = (sp == SP_RESET);
`else
  assign push_blocked = 1'b0;
  assign pop_blocked  = 1'b0;
`endif

endmodule

// File: rtl/mem_stack_unit.sv
// Memory access unit: load/store/push/pop sequencing with memory handshake and timeout.
module mem_stack_unit
  import mem_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LoadReq,
  input  logic        StoreReq,
  input  logic [1:0]  AddrSel,
  input  logic        SPUpdate,
  input  logic [15:0] PC,
  input  logic [15:0] OpAddr,
  input  logic [15:0] WData,
  output logic [15:0] RData,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] SP,
  output logic        Error,
  output logic        MemReq,
  output logic        MemWE,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWData,
  input  logic [15:0] MemRData,
  input  logic        MemAck
);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        is_load, is_pop, err_q;
  logic        accept, ack_hit, timeout, err_nxt, bound_fault;
  logic        push_blocked, pop_blocked;
  logic [15:0] sel_addr;

  wire dual_req  = LoadReq & StoreReq;
  wire any_req   = LoadReq ^ StoreReq;
  wire stack_req = any_req & SPUpdate;
  wire bad_sel   = any_req & ~SPUpdate & (AddrSel == SEL_RSVD);

  stack_pointer u_sp (
    .clk          (CLK),
    .rst_n        (RST_N),
    .push         (accept & stack_req & StoreReq),
    .pop_done     (ack_hit & is_pop),
    .capture      (accept),
    .restore      (timeout),
    .sp           (SP),
    .push_blocked (push_blocked),
    .pop_blocked  (pop_blocked)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    ack_hit     = 1'b0;
    timeout     = 1'b0;
    err_nxt     = 1'b0;
    bound_fault = 1'b0;
    case (state)
      ST_IDLE: begin
        bound_fault = stack_req & (StoreReq ? push_blocked : pop_blocked);
        if (dual_req | bound_fault | bad_sel) begin
          err_nxt = 1'b1;
        end else if (any_req) begin
          accept    = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (MemAck) begin
          ack_hit   = 1'b1;
          state_nxt = ST_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout   = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (AddrSel)
      SEL_PC:     sel_addr = PC;
      SEL_OPADDR: sel_addr = OpAddr;
      default:    sel_addr = SP;
    endcase
  end

  // Request attributes are frozen at acceptance and held for the whole access.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MemAddr  <= 16'h0000;
      MemWData <= 16'h0000;
      MemWE    <= 1'b0;
      RData    <= 16'h0000;
      wait_cnt <= 4'd0;
      is_load  <= 1'b0;
      is_pop   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_nxt;
      if (accept) begin
        wait_cnt <= 4'd0;
        is_load  <= LoadReq;
        is_pop   <= stack_req & LoadReq;
        MemWE    <= StoreReq;
        MemWData <= WData;
        MemAddr  <= stack_req ? (StoreReq ? SP - 16'd1 : SP) : sel_addr;
      end else if (state == ST_ACCESS) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (ack_hit && is_load)
        RData <= MemRData;
    end
  end

  assign MemReq = (state == ST_ACCESS);
  assign Busy   = (state == ST_ACCESS);
  assign Done   = (state == ST_DONE);
  assign Error  = err_q;

endmodule
